// File: rtl/apf_cart_loader_if.sv
// Loader bus: HPS ioctl download stream in, cart RAM write port and load status out.
// The checksum member exists only when APF_CART_CHECKSUM_EN is defined.
interface apf_cart_loader_if #(
    parameter int unsigned AW = 13
);
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_d;
    logic [AW:0]   cart_size;
    logic          cart_valid;
    logic          cpu_hold;
    logic          busy;
    logic          overflow;
`ifdef APF_CART_CHECKSUM_EN
    logic [7:0]    checksum;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  mem_we, mem_addr, mem_d, cart_size, cart_valid, cpu_hold, busy, overflow,
        input  checksum
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output mem_we, mem_addr, mem_d, cart_size, cart_valid, cpu_hold, busy, overflow,
        output checksum
    );
`else
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  mem_we, mem_addr, mem_d, cart_size, cart_valid, cpu_hold, busy, overflow
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output mem_we, mem_addr, mem_d, cart_size, cart_valid, cpu_hold, busy, overflow
    );
`endif
endinterface

// File: rtl/apf_cart_loader.sv
// Cartridge loader: ioctl download -> cart RAM port, 0xFF tail padding, CPU hold.
// Optional APF_CART_CHECKSUM_EN adds a modulo-256 sum of the bytes written during LOAD.
module apf_cart_loader #(
    parameter int unsigned AW    = 13,
    parameter logic [7:0]  INDEX = 8'd1,
    parameter int unsigned HOLD  = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    apf_cart_loader_if.slave  bus
);
    localparam int unsigned   SW        = AW + 1;
    localparam int unsigned   HW        = $clog2(HOLD + 2);
    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic          dl_q;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [SW-1:0] size_q, size_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          hold_q, hold_d;
    logic          busy_q, busy_d;
    logic [HW-1:0] cnt_q, cnt_d;
`ifdef APF_CART_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic          rise;
    logic          fall;
    logic          start;
    logic          in_win;
    logic [SW-1:0] addr_p1;

    // Edge detect against the registered download flag; only our index starts a load.
    assign rise    = bus.ioctl_download & ~dl_q;
    assign fall    = ~bus.ioctl_download & dl_q;
    assign start   = rise && (bus.ioctl_index == INDEX) && (state_q != S_LOAD);
    assign in_win  = (bus.ioctl_addr[24:AW] == '0);
    assign addr_p1 = {1'b0, bus.ioctl_addr[AW-1:0]} + SW'(1);

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
`ifdef APF_CART_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (start) begin
            // New download wins over any pad or hold still in progress.
            state_d = S_LOAD;
            valid_d = 1'b0;
            size_d  = '0;
            ovf_d   = 1'b0;
            hold_d  = 1'b1;
`ifdef APF_CART_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (bus.ioctl_wr) begin
                        if (in_win) begin
                            we_d   = 1'b1;
                            addr_d = bus.ioctl_addr[AW-1:0];
                            data_d = bus.ioctl_dout;
                            if (addr_p1 > size_q) begin
                                size_d = addr_p1;
                            end
`ifdef APF_CART_CHECKSUM_EN
                            csum_d = csum_q + bus.ioctl_dout;
`endif
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    // Pad pointer includes a write landing in the same cycle as the fall.
                    if (fall) begin
                        state_d = S_PAD;
                        ptr_d   = size_d;
                    end
                end
                S_PAD: begin
                    if (ptr_q[AW]) begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = ptr_q[AW-1:0];
                        data_d = 8'hFF;
                        ptr_d  = ptr_q + SW'(1);
                        if (ptr_q[AW-1:0] == LAST_ADDR) begin
                            state_d = S_HOLD;
                            cnt_d   = HOLD_LOAD;
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt_q <= HW'(1)) begin
                        state_d = S_IDLE;
                        hold_d  = 1'b0;
                        valid_d = (size_q != '0);
                    end else begin
                        cnt_d = cnt_q - HW'(1);
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dl_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef APF_CART_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            dl_q    <= bus.ioctl_download;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
`ifdef APF_CART_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_d      = data_q;
    assign bus.cart_size  = size_q;
    assign bus.cart_valid = valid_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = ovf_q;
`ifdef APF_CART_CHECKSUM_EN
    assign bus.checksum   = csum_q;
`endif

endmodule

// File: tb/tb_apf_cart_loader.sv
// Bench for apf_cart_loader: table rows, hand-written abort/reset sequences and random downloads
// checked against a cycle-stamped write-stream model built from the loader rules.
module tb_apf_cart_loader;
    localparam int unsigned AW   = 13;
    localparam int unsigned HOLD = 16;
    localparam int          WIN  = 1 << AW;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        int idx;
        int nbytes;
        bit fall_wr;
        int exp_size;
        bit exp_valid;
        bit exp_ovf;
        int exp_nwr;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset;

    apf_cart_loader_if #(.AW(AW)) bus ();

    apf_cart_loader #(.AW(AW), .INDEX(8'd1), .HOLD(HOLD)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int vectors;
    int miscompares;

    wr_t  wlog[$];
    wr_t  exp_wq[$];
    int   rel_q[$];
    int   exp_rel[$];
    logic hold_prev = 1'b0;
    bit   saw_busy = 1'b0;

    // Observed activity, stamped with the cycle it became visible.
    always @(negedge clk_sys) begin
        if (bus.mem_we) begin
            wr_t w;
            w.addr = int'(bus.mem_addr);
            w.data = int'(bus.mem_d);
            w.cyc  = cyc;
            wlog.push_back(w);
        end
        if (hold_prev && !bus.cpu_hold) rel_q.push_back(cyc);
        if (bus.busy) saw_busy = 1'b1;
        hold_prev = bus.cpu_hold;
    end

    // Reference model state
    int m_size, m_csum;
    bit m_valid, m_ovf;
    bit pend;
    int pend_from, pend_start, pend_rel;
    int b_addr[$], b_data[$], b_gap[$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int a, input int d, input int c);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.cyc  = c;
        exp_wq.push_back(w);
    endtask

    // Commit pad writes and the release that are visible up to cycle 'upto'.
    task automatic settle_pending(input int upto);
        if (pend) begin
            for (int a = pend_from; a < WIN; a++) begin
                if (pend_start + (a - pend_from) <= upto) push_exp(a, 255, pend_start + (a - pend_from));
            end
            if (pend_rel <= upto) begin
                exp_rel.push_back(pend_rel);
                m_valid = (m_size != 0);
            end
            pend = 1'b0;
        end
    endtask

    task automatic model_byte(input int a, input int d, input int c);
        if (a < WIN) begin
            push_exp(a, d, c + 1);
            if (a + 1 > m_size) m_size = a + 1;
            m_csum = (m_csum + d) % 256;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // Rise, send the queued bytes, then fall (optionally together with the last byte).
    task automatic run_dl(input int idx, input bit fall_wr);
        int c_f;
        int n;
        @(negedge clk_sys);
        bus.ioctl_index    = 8'(idx);
        bus.ioctl_download = 1'b1;
        if (idx == 1) begin
            settle_pending(cyc);
            m_size  = 0;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_csum  = 0;
        end
        c_f = cyc;
        for (int i = 0; i < b_addr.size(); i++) begin
            for (int g = 0; g < b_gap[i]; g++) begin
                @(negedge clk_sys);
                bus.ioctl_wr = 1'b0;
            end
            @(negedge clk_sys);
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(b_addr[i]);
            bus.ioctl_dout = 8'(b_data[i]);
            if (fall_wr && i == b_addr.size() - 1) bus.ioctl_download = 1'b0;
            if (idx == 1) model_byte(b_addr[i], b_data[i], cyc);
            c_f = cyc;
        end
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        if (bus.ioctl_download) begin
            bus.ioctl_download = 1'b0;
            c_f = cyc;
        end
        if (idx == 1) begin
            n          = WIN - m_size;
            pend       = 1'b1;
            pend_from  = m_size;
            pend_start = c_f + 2;
            pend_rel   = c_f + 1 + ((n > 0) ? n : 1) + HOLD;
        end
    endtask

    task automatic wait_idle();
        int target;
        target = pend ? pend_rel + 2 : cyc + 3;
        while (cyc < target) @(negedge clk_sys);
        #1;
        settle_pending(cyc);
    endtask

    task automatic checkpoint(input string name);
        int bad;
        bad = -1;
        chk({name, " write count"}, wlog.size(), exp_wq.size());
        for (int i = 0; i < wlog.size() && i < exp_wq.size(); i++) begin
            if (wlog[i].addr != exp_wq[i].addr || wlog[i].data != exp_wq[i].data ||
                wlog[i].cyc != exp_wq[i].cyc) begin
                bad = i;
                break;
            end
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s write stream #%0d: got addr %0d data %0d cyc %0d expected addr %0d data %0d cyc %0d",
                     name, bad, wlog[bad].addr, wlog[bad].data, wlog[bad].cyc,
                     exp_wq[bad].addr, exp_wq[bad].data, exp_wq[bad].cyc);
        end
        chk({name, " release count"}, rel_q.size(), exp_rel.size());
        for (int i = 0; i < rel_q.size() && i < exp_rel.size(); i++)
            chk({name, " release cycle"}, rel_q[i], exp_rel[i]);
        chk({name, " cart_size"}, int'(bus.cart_size), m_size);
        chk({name, " cart_valid"}, int'(bus.cart_valid), int'(m_valid));
        chk({name, " overflow"}, int'(bus.overflow), int'(m_ovf));
        chk({name, " busy"}, int'(bus.busy), 0);
        chk({name, " cpu_hold"}, int'(bus.cpu_hold), 0);
`ifdef APF_CART_CHECKSUM_EN
        chk({name, " checksum"}, int'(bus.checksum), m_csum);
`endif
        wlog.delete();
        exp_wq.delete();
        rel_q.delete();
        exp_rel.delete();
    endtask

    task automatic seq_bytes(input int n);
        b_addr.delete();
        b_data.delete();
        b_gap.delete();
        for (int a = 0; a < n; a++) begin
            b_addr.push_back(a);
            b_data.push_back(a % 256);
            b_gap.push_back(0);
        end
    endtask

    vec_t tab[6];

    initial begin
        bit force1;

        tab[0] = '{1, 4096, 1'b0, 4096, 1'b1, 1'b0, 8192};
        tab[1] = '{2,  100, 1'b0, 4096, 1'b1, 1'b0,    0};
        tab[2] = '{1, 8200, 1'b0, 8192, 1'b1, 1'b1, 8192};
        tab[3] = '{1,    0, 1'b0,    0, 1'b0, 1'b0, 8192};
        tab[4] = '{1, 8192, 1'b1, 8192, 1'b1, 1'b0, 8192};
        tab[5] = '{1,    1, 1'b1,    1, 1'b1, 1'b0, 8192};

        vectors = 0;
        miscompares = 0;
        m_size = 0; m_csum = 0; m_valid = 1'b0; m_ovf = 1'b0; pend = 1'b0;
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        repeat (3) @(negedge clk_sys);
        #1;
        chk("reset mem_we", int'(bus.mem_we), 0);
        chk("reset cart_size", int'(bus.cart_size), 0);
        chk("reset cpu_hold", int'(bus.cpu_hold), 0);
        chk("reset busy", int'(bus.busy), 0);
        reset = 1'b0;
        @(negedge clk_sys);
        #1;
        wlog.delete();
        rel_q.delete();

        // Table rows: sequential downloads with hand-derived end state
        for (int i = 0; i < 6; i++) begin
            seq_bytes(tab[i].nbytes);
            saw_busy = 1'b0;
            run_dl(tab[i].idx, tab[i].fall_wr);
            wait_idle();
            chk($sformatf("row%0d busy seen", i), int'(saw_busy), (tab[i].idx == 1) ? 1 : 0);
            chk($sformatf("row%0d cart_size", i), int'(bus.cart_size), tab[i].exp_size);
            chk($sformatf("row%0d cart_valid", i), int'(bus.cart_valid), int'(tab[i].exp_valid));
            chk($sformatf("row%0d overflow", i), int'(bus.overflow), int'(tab[i].exp_ovf));
            chk($sformatf("row%0d writes", i), wlog.size(), tab[i].exp_nwr);
            checkpoint($sformatf("row%0d", i));
        end

        // Write on the falling cycle, then a new rise in the middle of padding
        b_addr.delete(); b_data.delete(); b_gap.delete();
        for (int a = 0; a <= 10; a++) begin
            b_addr.push_back(a);
            b_data.push_back(int'($urandom_range(0, 255)));
            b_gap.push_back(0);
        end
        run_dl(1, 1'b1);
        repeat (20) @(negedge clk_sys);
        #1;
        chk("abort cart_size", int'(bus.cart_size), 11);
        chk("abort cpu_hold mid pad", int'(bus.cpu_hold), 1);
        chk("abort busy mid pad", int'(bus.busy), 1);
        chk("abort first pad addr", (wlog.size() > 11) ? wlog[11].addr : -1, 11);
        b_addr.delete(); b_data.delete(); b_gap.delete();
        b_addr.push_back(5);  b_data.push_back(8'h5A); b_gap.push_back(1);
        b_addr.push_back(6);  b_data.push_back(8'hA5); b_gap.push_back(0);
        run_dl(1, 1'b0);
        #1;
        chk("abort cpu_hold after rise", int'(bus.cpu_hold), 1);
        chk("abort size after reload", int'(bus.cart_size), 7);
        wait_idle();
        checkpoint("abort");

        // Checksum bytes
        b_addr.delete(); b_data.delete(); b_gap.delete();
        b_addr.push_back(0); b_data.push_back(8'h01); b_gap.push_back(0);
        b_addr.push_back(1); b_data.push_back(8'hFF); b_gap.push_back(0);
        b_addr.push_back(2); b_data.push_back(8'h80); b_gap.push_back(0);
        run_dl(1, 1'b0);
        wait_idle();
        chk("csum cart_size", int'(bus.cart_size), 3);
`ifdef APF_CART_CHECKSUM_EN
        chk("csum value", int'(bus.checksum), 8'h80);
`endif
        checkpoint("csum");

        // Randomized downloads, some aborted by the next rise
        force1 = 1'b0;
        for (int r = 0; r < 12; r++) begin
            int idx;
            int n;
            int mode;
            int a;
            bit fw;
            bit abort;
            idx   = (!force1 && $urandom_range(0, 3) == 0) ? 2 : 1;
            fw    = 1'($urandom_range(0, 1));
            abort = (r < 11) && (idx == 1) && ($urandom_range(0, 2) == 0);
            n     = int'($urandom_range(1, 24));
            b_addr.delete(); b_data.delete(); b_gap.delete();
            for (int k = 0; k < n; k++) begin
                mode = int'($urandom_range(0, 9));
                if (mode < 7)      a = int'($urandom_range(WIN - 64, WIN - 1));
                else if (mode < 9) a = int'($urandom_range(WIN, WIN + 100));
                else               a = int'($urandom & 32'h01FF_FFFF);
                b_addr.push_back(a);
                b_data.push_back(int'($urandom_range(0, 255)));
                b_gap.push_back(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            run_dl(idx, fw);
            force1 = abort;
            if (abort) begin
                repeat ($urandom_range(0, 40)) @(negedge clk_sys);
            end else begin
                wait_idle();
                checkpoint($sformatf("rand%0d", r));
            end
        end

        // Asynchronous reset in the middle of LOAD
        @(negedge clk_sys);
        bus.ioctl_index    = 8'd1;
        bus.ioctl_download = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_sys);
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(k);
            bus.ioctl_dout = 8'(k + 8'h40);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async mem_we", int'(bus.mem_we), 0);
        chk("async mem_addr", int'(bus.mem_addr), 0);
        chk("async mem_d", int'(bus.mem_d), 0);
        chk("async cart_size", int'(bus.cart_size), 0);
        chk("async cart_valid", int'(bus.cart_valid), 0);
        chk("async overflow", int'(bus.overflow), 0);
        chk("async cpu_hold", int'(bus.cpu_hold), 0);
        chk("async busy", int'(bus.busy), 0);
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        #1;
        wlog.delete(); exp_wq.delete(); rel_q.delete(); exp_rel.delete();
        m_size = 0; m_csum = 0; m_valid = 1'b0; m_ovf = 1'b0; pend = 1'b0;
        repeat (5) @(negedge clk_sys);
        #1;
        checkpoint("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
